// File: rtl/ssp_word_accum_if.sv
// ssp_word_accum_if: word-stream interface of the SSP window accumulator.
//   din_valid  master->slave  word qualifier
//   din        master->slave  packed 32-bit word, four unsigned bytes
//   dout       slave->master  saturated window total (ACC_W bits)
//   dout_valid slave->master  one-cycle pulse when dout updates
//   sat        slave->master  window total saturated
interface ssp_word_accum_if #(
  parameter int unsigned ACC_W = 16
);
  logic             din_valid;
  logic [31:0]      din;
  logic [ACC_W-1:0] dout;
  logic             dout_valid;
  logic             sat;

  modport master (
    output din_valid,
    output din,
    input  dout,
    input  dout_valid,
    input  sat
  );

  modport slave (
    input  din_valid,
    input  din,
    output dout,
    output dout_valid,
    output sat
  );
endinterface

// File: rtl/ssp_word_accum.sv
// ssp_word_accum: sums the four unsigned bytes of each accepted 32-bit word
// (stage 1) and accumulates those byte sums over windows of N_WORDS words
// (stage 2). One saturated total per window is emitted with a one-cycle
// dout_valid pulse; dout and sat hold until the next window completes.
//
// Ports:
//   clk   system clock, all state on posedge
//   rst   asynchronous active-low reset
//   bus   ssp_word_accum_if slave: din_valid, din in; dout, dout_valid, sat out
//
// Configuration macro: APPROX_LOA_EN selects a lower-part-OR approximate
// adder (APPROX_BITS low bits) for the stage-2 add; otherwise the add is exact.
module ssp_word_accum #(
  parameter int unsigned N_WORDS     = 4,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  ssp_word_accum_if.slave   bus
);

  localparam int unsigned CntW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N_WORDS - 1);

  // Window state is implied by cnt: IDLE at the window start, ACC inside it.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  // Elaboration-time parameter range checks.
  if (N_WORDS < 1) begin : g_bad_n_words
    $error("ssp_word_accum: N_WORDS must be at least 1");
  end
  if (ACC_W < 10) begin : g_bad_acc_w
    $error("ssp_word_accum: ACC_W must be at least 10");
  end
  if (APPROX_BITS < 1 || APPROX_BITS >= ACC_W) begin : g_bad_approx_bits
    $error("ssp_word_accum: APPROX_BITS must be in 1..ACC_W-1");
  end

  // Stage 1 state
  logic [9:0]       bsum_q;
  logic             s1_valid_q;

  // Stage 2 state
  logic [ACC_W-1:0] acc_q,  acc_d;
  logic [CntW-1:0]  cnt_q,  cnt_d;
  logic             sticky_q, sticky_d;
  logic [ACC_W-1:0] dout_q, dout_d;
  logic             sat_q,  sat_d;
  logic             dout_valid_d, dout_valid_q;

  logic [0:0]       state;
  logic             last_word;
  logic [ACC_W-1:0] acc_in;
  logic [ACC_W-1:0] bsum_ext;
  logic [ACC_W:0]   sum;
  logic             sat_now;
  logic [ACC_W-1:0] result;

  // ---------------------------------------------------------------------------
  // Stage 1: exact byte sum. bsum only loads on a valid word, so X on din
  // during gaps never reaches the accumulator.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bsum_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.din_valid;
      if (bus.din_valid) begin
        bsum_q <= 10'(bus.din[31:24]) + 10'(bus.din[23:16])
                + 10'(bus.din[15:8])  + 10'(bus.din[7:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate adder
  // ---------------------------------------------------------------------------
  assign state     = (cnt_q == '0) ? ST_IDLE : ST_ACC;
  assign last_word = (cnt_q == CntLast);
  // The first word of a window always starts from zero, which also covers a
  // new window beginning on the same edge the previous one is emitted.
  assign acc_in    = (state == ST_IDLE) ? '0 : acc_q;
  assign bsum_ext  = ACC_W'(bsum_q);

`ifdef APPROX_LOA_EN
  localparam int unsigned HiW = ACC_W - APPROX_BITS;

  logic [APPROX_BITS-1:0] loa_lo;
  logic                   loa_cin;
  logic [HiW:0]           loa_hi;

  always_comb begin
    loa_lo  = acc_in[APPROX_BITS-1:0] | bsum_ext[APPROX_BITS-1:0];
    loa_cin = acc_in[APPROX_BITS-1] & bsum_ext[APPROX_BITS-1];
    loa_hi  = {1'b0, acc_in[ACC_W-1:APPROX_BITS]} + {1'b0, bsum_ext[ACC_W-1:APPROX_BITS]}
            + (HiW + 1)'(loa_cin);
    // Carry-out of the upper part lands in sum[ACC_W].
    sum     = {loa_hi, loa_lo};
  end
`else
  assign sum = {1'b0, acc_in} + {1'b0, bsum_ext};
`endif

  assign sat_now = sum[ACC_W] | ((state == ST_ACC) & sticky_q);
  assign result  = sat_now ? '1 : sum[ACC_W-1:0];

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sticky_d     = sticky_q;
    dout_d       = dout_q;
    sat_d        = sat_q;
    dout_valid_d = 1'b0;
    if (s1_valid_q) begin
      if (last_word) begin
        dout_d       = result;
        sat_d        = sat_now;
        dout_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
        sticky_d     = 1'b0;
      end else begin
        acc_d        = result;
        cnt_d        = cnt_q + 1'b1;
        sticky_d     = sat_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
      dout_q       <= '0;
      sat_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sticky_q     <= sticky_d;
      dout_q       <= dout_d;
      sat_q        <= sat_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sat        = sat_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ssp_word_accum.sv
// Scoreboard bench for ssp_word_accum. Three instances cover N_WORDS=2/ACC_W=16,
// N_WORDS=4/ACC_W=16 and N_WORDS=2/ACC_W=10. Expected totals are pushed when
// the closing word of a window is driven; per-instance monitors pop and compare
// dout, sat and the arrival edge whenever dout_valid is seen.
module tb_ssp_word_accum;

`ifdef APPROX_LOA_EN
  localparam int ExpA   = 637;  // 0x118 + 0x15D under LOA
  localparam int ExpB2B = 4;    // 4 | 4 never carries with APPROX_BITS=4
  localparam int ExpGap = 4;
  localparam int ExpOne = 1;    // 1 | 1
`else
  localparam int ExpA   = 629;
  localparam int ExpB2B = 8;
  localparam int ExpGap = 16;
  localparam int ExpOne = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssp_word_accum_if #(.ACC_W(16)) bus2 ();
  ssp_word_accum_if #(.ACC_W(16)) bus4 ();
  ssp_word_accum_if #(.ACC_W(10)) bus10 ();

  ssp_word_accum #(.N_WORDS(2), .ACC_W(16), .APPROX_BITS(4)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );
  ssp_word_accum #(.N_WORDS(4), .ACC_W(16), .APPROX_BITS(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );
  ssp_word_accum #(.N_WORDS(2), .ACC_W(10), .APPROX_BITS(4)) u_dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10)
  );

  typedef struct {
    int d;
    bit s;
    int at_edge;
  } exp_t;

  exp_t q[3][$];
  int checks = 0;
  int errors = 0;
  int edges  = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_pulse(input int sel, input int d, input bit s);
    exp_t e;
    checks++;
    if (q[sel].size() == 0) begin
      errors++;
      $display("FAIL pulse%0d unexpected dout=%0d sat=%0b at edge %0d, required no pulse",
               sel, d, s, edges);
    end else begin
      e = q[sel].pop_front();
      if (d != e.d || s != e.s || edges != e.at_edge) begin
        errors++;
        $display("FAIL pulse%0d dout=%0d sat=%0b edge=%0d required dout=%0d sat=%0b edge=%0d",
                 sel, d, s, edges, e.d, e.s, e.at_edge);
      end
    end
  endtask

  always @(negedge clk) if (rst && bus2.dout_valid)  check_pulse(0, int'(bus2.dout), bus2.sat);
  always @(negedge clk) if (rst && bus4.dout_valid)  check_pulse(1, int'(bus4.dout), bus4.sat);
  always @(negedge clk) if (rst && bus10.dout_valid) check_pulse(2, int'(bus10.dout), bus10.sat);

  task automatic drive(input int sel, input logic [31:0] w, input logic v);
    case (sel)
      0: begin bus2.din  = w; bus2.din_valid  = v; end
      1: begin bus4.din  = w; bus4.din_valid  = v; end
      default: begin bus10.din = w; bus10.din_valid = v; end
    endcase
  endtask

  // Drive one word for one cycle; returns at posedge+1 with din_valid low.
  task automatic send(input int sel, input logic [31:0] w, input bit last,
                      input int exp_d, input bit exp_s);
    exp_t e;
    if (last) begin
      e.d = exp_d;
      e.s = exp_s;
      // Accepted at the next edge, summed and visible after the one after.
      e.at_edge = edges + 2;
      q[sel].push_back(e);
    end
    drive(sel, w, 1'b1);
    @(posedge clk);
    #1;
    drive(sel, 32'hxxxx_xxxx, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    bus2.din_valid = 1'b0;  bus2.din = '0;
    bus4.din_valid = 1'b0;  bus4.din = '0;
    bus10.din_valid = 1'b0; bus10.din = '0;

    // Reset held with live random traffic.
    #1 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(0, $urandom, 1'b1);
      drive(1, $urandom, 1'b1);
      drive(2, $urandom, 1'b1);
      @(negedge clk);
      check_val("rst_dout2", int'(bus2.dout), 0);
      check_val("rst_dv2", int'(bus2.dout_valid), 0);
      check_val("rst_sat2", int'(bus2.sat), 0);
      check_val("rst_dout4", int'(bus4.dout), 0);
      check_val("rst_dv4", int'(bus4.dout_valid), 0);
      check_val("rst_sat4", int'(bus4.sat), 0);
      check_val("rst_dout10", int'(bus10.dout), 0);
      check_val("rst_dv10", int'(bus10.dout_valid), 0);
      check_val("rst_sat10", int'(bus10.sat), 0);
    end
    @(posedge clk);
    #1;
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    drive(2, '0, 1'b0);
    rst = 1'b1;
    idle(1);

    // Main function, then a second window back-to-back with no bubble.
    send(0, 32'h940F_5124, 1'b0, 0, 1'b0);
    send(0, 32'h67F3_0102, 1'b1, ExpA, 1'b0);
    send(0, 32'h0101_0101, 1'b0, 0, 1'b0);
    send(0, 32'h0101_0101, 1'b1, ExpB2B, 1'b0);
    idle(3);

    // Gaps inside a window freeze state; only the 4th word closes it.
    for (int i = 0; i < 4; i++) begin
      send(1, 32'h0101_0101, (i == 3), ExpGap, 1'b0);
      if (i < 3) idle(3);
    end
    idle(3);

    // Saturation at ACC_W=10, then a clean window clears sat.
    send(2, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    send(2, 32'hFFFF_FFFF, 1'b1, 1023, 1'b1);
    send(2, 32'h0000_0001, 1'b0, 0, 1'b0);
    send(2, 32'h0000_0001, 1'b1, ExpOne, 1'b0);
    idle(3);

    // Asynchronous reset mid-window with the first word still in stage 1.
    send(0, 32'h1010_1010, 1'b0, 0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check_val("async_rst_dout2", int'(bus2.dout), 0);
    check_val("async_rst_sat10", int'(bus10.sat), 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    send(0, 32'h0100_0000, 1'b0, 0, 1'b0);
    send(0, 32'h0200_0000, 1'b1, 3, 1'b0);
    idle(4);

    check_val("drain_q0", q[0].size(), 0);
    check_val("drain_q1", q[1].size(), 0);
    check_val("drain_q2", q[2].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
